// File: rtl/i2s_rx.sv
// I2S receiver: synchronizes sclk/lrclk/sdata into the clk domain, deserializes
// MSB-first words and presents left/right pairs with a one-clk sample_valid pulse.
module i2s_rx #(
  parameter int AUDIO_DW = 16
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                sclk,
  input  logic                lrclk,
  input  logic                sdata,
  output logic [AUDIO_DW-1:0] left_chan,
  output logic [AUDIO_DW-1:0] right_chan,
  output logic                sample_valid,
  output logic                frame_err
);

  localparam logic [7:0] DW_C = 8'(AUDIO_DW);

  function automatic logic [7:0] sat_inc(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

  // [0] = sync stage 1, [1] = sync stage 2, [2] = history
  logic [2:0]          sclk_q;
  logic [2:0]          lrclk_q;
  logic [2:0]          sdata_q;
  logic                rise_p0;
  logic                vld_p1;
  logic                lr_p1;
  logic                sd_p1;

  logic [7:0]          cnt_q;
  logic [7:0]          cnt_d;
  logic [AUDIO_DW-1:0] sr_q;
  logic [AUDIO_DW-1:0] word_d;
  logic [AUDIO_DW-1:0] pend_left_q;
  logic                lr_prev_q;
  logic                first_slot_q;
  logic                have_left_q;
  logic                lr_chg_d;

  // Stage p0: synchronizers and sclk rise detection
  always_ff @(posedge clk) begin
    if (reset) begin
      sclk_q  <= 3'b111;
      lrclk_q <= 3'b111;
      sdata_q <= 3'b000;
      vld_p1  <= 1'b0;
    end else begin
      sclk_q  <= {sclk_q[1:0], sclk};
      lrclk_q <= {lrclk_q[1:0], lrclk};
      sdata_q <= {sdata_q[1:0], sdata};
      vld_p1  <= rise_p0;
    end
  end

  assign rise_p0 = sclk_q[1] & ~sclk_q[2];
  // One cycle after detection the history flops hold the stage-2 values seen at the rise.
  assign lr_p1   = lrclk_q[2];
  assign sd_p1   = sdata_q[2];

  always_comb begin
    cnt_d    = sat_inc(cnt_q);
    word_d   = (cnt_q < DW_C) ? {sr_q[AUDIO_DW-2:0], sd_p1} : sr_q;
    // The very first rise after reset only primes lr_prev_q; it cannot close a slot.
    lr_chg_d = vld_p1 && (lr_p1 != lr_prev_q) && !(first_slot_q && (cnt_q == 8'd0));
  end

  // Stage p1: deserializer, pairing and registered outputs
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q        <= 8'd0;
      sr_q         <= '0;
      pend_left_q  <= '0;
      lr_prev_q    <= 1'b1;
      first_slot_q <= 1'b1;
      have_left_q  <= 1'b0;
      left_chan    <= '0;
      right_chan   <= '0;
      sample_valid <= 1'b0;
      frame_err    <= 1'b0;
    end else begin
      sample_valid <= 1'b0;
      frame_err    <= 1'b0;
      if (vld_p1) begin
        lr_prev_q <= lr_p1;
        if (lr_chg_d) begin
          cnt_q        <= 8'd0;
          sr_q         <= '0;
          first_slot_q <= 1'b0;
          if (!first_slot_q) begin
            if (cnt_d != DW_C) begin
              frame_err   <= 1'b1;
              have_left_q <= 1'b0;
            end else if (!lr_prev_q) begin
              pend_left_q <= word_d;
              have_left_q <= 1'b1;
            end else if (have_left_q) begin
              left_chan    <= pend_left_q;
              right_chan   <= word_d;
              sample_valid <= 1'b1;
              have_left_q  <= 1'b0;
            end
          end
        end else begin
          cnt_q <= cnt_d;
          if (cnt_q < DW_C) begin
            sr_q <= {sr_q[AUDIO_DW-2:0], sd_p1};
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_i2s_rx.sv
// Directed bench for i2s_rx: drives I2S frames bit by bit and checks received pairs and pulses.
module tb_i2s_rx;

  localparam int DW = 16;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          sclk = 1'b1;
  logic          lrclk = 1'b1;
  logic          sdata = 1'b0;
  logic [DW-1:0] left_chan;
  logic [DW-1:0] right_chan;
  logic          sample_valid;
  logic          frame_err;

  i2s_rx #(.AUDIO_DW(DW)) dut (
    .clk          (clk),
    .reset        (reset),
    .sclk         (sclk),
    .lrclk        (lrclk),
    .sdata        (sdata),
    .left_chan    (left_chan),
    .right_chan   (right_chan),
    .sample_valid (sample_valid),
    .frame_err    (frame_err)
  );

  always #5 clk = ~clk;

  int tests_run = 0;
  int tests_failed = 0;
  int sv_cnt = 0;
  int fe_cnt = 0;
  int consec_err = 0;
  int last_lat = -1;
  logic sv_prev = 1'b0;
  logic fe_prev = 1'b0;
  logic [DW-1:0] cap_l[$];
  logic [DW-1:0] cap_r[$];
  bit q_ch[$];
  bit q_d[$];

  // Pulse monitor: counts pulses, captures pairs, flags back-to-back pulses
  always @(negedge clk) begin
    if (sample_valid === 1'b1) begin
      sv_cnt++;
      cap_l.push_back(left_chan);
      cap_r.push_back(right_chan);
    end
    if (frame_err === 1'b1) fe_cnt++;
    if ((sample_valid && sv_prev) || (frame_err && fe_prev)) consec_err++;
    sv_prev = sample_valid;
    fe_prev = frame_err;
  end

  initial begin
    #3000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic push_slot(input bit ch, input logic [31:0] w, input int n);
    for (int j = n - 1; j >= 0; j--) begin
      q_ch.push_back(ch);
      q_d.push_back((j < 32) ? w[j] : 1'b0);
    end
  endtask

  // lrclk leads the data by one bit; the last bit optionally toggles lrclk to close its word.
  task automatic play(input int half, input bit toggle_end);
    int n;
    n = q_ch.size();
    last_lat = -1;
    @(negedge clk);
    for (int p = 0; p < n; p++) begin
      sclk = 1'b0;
      if (p < n - 1) lrclk = q_ch[p+1];
      else           lrclk = toggle_end ? !q_ch[p] : q_ch[p];
      sdata = q_d[p];
      repeat (half) @(negedge clk);
      sclk = 1'b1;
      if (p == n - 1) begin
        for (int k = 1; k <= 8; k++) begin
          @(negedge clk);
          if (last_lat < 0 && (sample_valid === 1'b1 || frame_err === 1'b1)) last_lat = k;
        end
      end else begin
        repeat (half) @(negedge clk);
      end
    end
    q_ch.delete();
    q_d.delete();
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (4) @(negedge clk);
    tests_run++;
    if (left_chan !== 16'h0000) begin tests_failed++; $display("FAIL reset_left: got %h expected 0000", left_chan); end
    tests_run++;
    if (right_chan !== 16'h0000) begin tests_failed++; $display("FAIL reset_right: got %h expected 0000", right_chan); end
    tests_run++;
    if (sample_valid !== 1'b0) begin tests_failed++; $display("FAIL reset_sv: got %b expected 0", sample_valid); end
    tests_run++;
    if (frame_err !== 1'b0) begin tests_failed++; $display("FAIL reset_fe: got %b expected 0", frame_err); end
    reset = 1'b0;
    repeat (4) @(negedge clk);
  endtask

  task automatic test_basic();
    int sv0, fe0;
    sv0 = sv_cnt; fe0 = fe_cnt;
    push_slot(1'b0, 32'h1234, 16); push_slot(1'b1, 32'hABCD, 16);
    push_slot(1'b0, 32'h1234, 16); push_slot(1'b1, 32'hABCD, 16);
    play(4, 1'b1);
    repeat (4) @(negedge clk);
    tests_run++;
    if (sv_cnt - sv0 !== 1) begin tests_failed++; $display("FAIL basic_sv_count: got %0d expected 1", sv_cnt - sv0); end
    tests_run++;
    if (fe_cnt - fe0 !== 0) begin tests_failed++; $display("FAIL basic_fe_count: got %0d expected 0", fe_cnt - fe0); end
    tests_run++;
    if (left_chan !== 16'h1234) begin tests_failed++; $display("FAIL basic_left: got %h expected 1234", left_chan); end
    tests_run++;
    if (right_chan !== 16'hABCD) begin tests_failed++; $display("FAIL basic_right: got %h expected abcd", right_chan); end
    tests_run++;
    if (last_lat !== 4) begin tests_failed++; $display("FAIL basic_latency: got %0d expected 4", last_lat); end
    tests_run++;
    if (consec_err !== 0) begin tests_failed++; $display("FAIL basic_consecutive: got %0d expected 0", consec_err); end
  endtask

  task automatic test_short_right();
    int sv0, fe0;
    sv0 = sv_cnt; fe0 = fe_cnt;
    push_slot(1'b0, 32'h1111, 16); push_slot(1'b1, 32'h2222, 15);
    play(4, 1'b1);
    repeat (4) @(negedge clk);
    tests_run++;
    if (fe_cnt - fe0 !== 1) begin tests_failed++; $display("FAIL short_fe_count: got %0d expected 1", fe_cnt - fe0); end
    tests_run++;
    if (sv_cnt - sv0 !== 0) begin tests_failed++; $display("FAIL short_sv_count: got %0d expected 0", sv_cnt - sv0); end
    tests_run++;
    if (left_chan !== 16'h1234) begin tests_failed++; $display("FAIL short_left_hold: got %h expected 1234", left_chan); end
    tests_run++;
    if (right_chan !== 16'hABCD) begin tests_failed++; $display("FAIL short_right_hold: got %h expected abcd", right_chan); end
    tests_run++;
    if (last_lat !== 4) begin tests_failed++; $display("FAIL short_fe_latency: got %0d expected 4", last_lat); end
    sv0 = sv_cnt; fe0 = fe_cnt;
    push_slot(1'b0, 32'h3333, 16); push_slot(1'b1, 32'h4444, 16);
    play(4, 1'b1);
    repeat (4) @(negedge clk);
    tests_run++;
    if (sv_cnt - sv0 !== 1 || fe_cnt - fe0 !== 0) begin
      tests_failed++; $display("FAIL short_recover_pulses: got sv=%0d fe=%0d expected sv=1 fe=0", sv_cnt - sv0, fe_cnt - fe0);
    end
    tests_run++;
    if (left_chan !== 16'h3333 || right_chan !== 16'h4444) begin
      tests_failed++; $display("FAIL short_recover_pair: got %h/%h expected 3333/4444", left_chan, right_chan);
    end
  endtask

  task automatic test_long_left();
    int sv0, fe0;
    sv0 = sv_cnt; fe0 = fe_cnt;
    push_slot(1'b0, 32'h1ABCD, 17); push_slot(1'b1, 32'h5555, 16);
    play(4, 1'b1);
    repeat (4) @(negedge clk);
    tests_run++;
    if (fe_cnt - fe0 !== 1 || sv_cnt - sv0 !== 0) begin
      tests_failed++; $display("FAIL long17_pulses: got sv=%0d fe=%0d expected sv=0 fe=1", sv_cnt - sv0, fe_cnt - fe0);
    end
    tests_run++;
    if (left_chan !== 16'h3333 || right_chan !== 16'h4444) begin
      tests_failed++; $display("FAIL long17_hold: got %h/%h expected 3333/4444", left_chan, right_chan);
    end
    // 272 bits would alias to 16 if the counter wrapped at 256
    sv0 = sv_cnt; fe0 = fe_cnt;
    push_slot(1'b0, 32'h0000BEEF, 272); push_slot(1'b1, 32'h5A5A, 16);
    play(4, 1'b1);
    repeat (4) @(negedge clk);
    tests_run++;
    if (fe_cnt - fe0 !== 1 || sv_cnt - sv0 !== 0) begin
      tests_failed++; $display("FAIL long272_pulses: got sv=%0d fe=%0d expected sv=0 fe=1", sv_cnt - sv0, fe_cnt - fe0);
    end
    sv0 = sv_cnt; fe0 = fe_cnt;
    push_slot(1'b0, 32'h0F0F, 16); push_slot(1'b1, 32'hF0F0, 16);
    play(4, 1'b1);
    repeat (4) @(negedge clk);
    tests_run++;
    if (sv_cnt - sv0 !== 1 || fe_cnt - fe0 !== 0) begin
      tests_failed++; $display("FAIL long_recover_pulses: got sv=%0d fe=%0d expected sv=1 fe=0", sv_cnt - sv0, fe_cnt - fe0);
    end
    tests_run++;
    if (left_chan !== 16'h0F0F || right_chan !== 16'hF0F0) begin
      tests_failed++; $display("FAIL long_recover_pair: got %h/%h expected 0f0f/f0f0", left_chan, right_chan);
    end
  endtask

  task automatic test_reset_mid();
    int sv0, fe0;
    push_slot(1'b0, 32'hAA, 8);
    play(4, 1'b0);
    sv0 = sv_cnt; fe0 = fe_cnt;
    reset = 1'b1;
    repeat (3) @(negedge clk);
    tests_run++;
    if (left_chan !== 16'h0000 || right_chan !== 16'h0000) begin
      tests_failed++; $display("FAIL midreset_clear: got %h/%h expected 0000/0000", left_chan, right_chan);
    end
    reset = 1'b0;
    repeat (4) @(negedge clk);
    for (int i = 0; i < 3; i++) begin
      push_slot(1'b0, 32'h8001, 16); push_slot(1'b1, 32'h7FFE, 16);
    end
    play(4, 1'b1);
    repeat (4) @(negedge clk);
    tests_run++;
    if (sv_cnt - sv0 !== 2) begin tests_failed++; $display("FAIL midreset_sv_count: got %0d expected 2", sv_cnt - sv0); end
    tests_run++;
    if (fe_cnt - fe0 !== 0) begin tests_failed++; $display("FAIL midreset_fe_count: got %0d expected 0", fe_cnt - fe0); end
    tests_run++;
    if (left_chan !== 16'h8001 || right_chan !== 16'h7FFE) begin
      tests_failed++; $display("FAIL midreset_pair: got %h/%h expected 8001/7ffe", left_chan, right_chan);
    end
  endtask

  task automatic test_min_sclk();
    int sv0, fe0, b;
    logic [DW-1:0] exp_l[4];
    logic [DW-1:0] exp_r[4];
    sv0 = sv_cnt; fe0 = fe_cnt; b = cap_l.size();
    for (int i = 0; i < 4; i++) begin
      exp_l[i] = DW'($urandom);
      exp_r[i] = DW'($urandom);
      push_slot(1'b0, {16'h0, exp_l[i]}, 16); push_slot(1'b1, {16'h0, exp_r[i]}, 16);
    end
    play(2, 1'b1);
    repeat (4) @(negedge clk);
    tests_run++;
    if (sv_cnt - sv0 !== 4 || fe_cnt - fe0 !== 0) begin
      tests_failed++; $display("FAIL minsclk_pulses: got sv=%0d fe=%0d expected sv=4 fe=0", sv_cnt - sv0, fe_cnt - fe0);
    end
    for (int i = 0; i < 4; i++) begin
      tests_run++;
      if (cap_l.size() <= b + i) begin
        tests_failed++; $display("FAIL minsclk_pair%0d: got no pair expected %h/%h", i, exp_l[i], exp_r[i]);
      end else if (cap_l[b+i] !== exp_l[i] || cap_r[b+i] !== exp_r[i]) begin
        tests_failed++; $display("FAIL minsclk_pair%0d: got %h/%h expected %h/%h", i, cap_l[b+i], cap_r[b+i], exp_l[i], exp_r[i]);
      end
    end
    tests_run++;
    if (consec_err !== 0) begin tests_failed++; $display("FAIL minsclk_consecutive: got %0d expected 0", consec_err); end
  endtask

  task automatic test_back_to_back_ramp();
    int sv0, fe0, b;
    logic [DW-1:0] exp_l[6];
    logic [DW-1:0] exp_r[6];
    sv0 = sv_cnt; fe0 = fe_cnt; b = cap_l.size();
    for (int i = 0; i < 6; i++) begin
      exp_l[i] = DW'(16'h7FFD + 16'(i));
      exp_r[i] = DW'(16'h0002 - 16'(i));
      push_slot(1'b0, {16'h0, exp_l[i]}, 16); push_slot(1'b1, {16'h0, exp_r[i]}, 16);
    end
    play(2, 1'b1);
    repeat (4) @(negedge clk);
    tests_run++;
    if (sv_cnt - sv0 !== 6 || fe_cnt - fe0 !== 0) begin
      tests_failed++; $display("FAIL ramp_pulses: got sv=%0d fe=%0d expected sv=6 fe=0", sv_cnt - sv0, fe_cnt - fe0);
    end
    for (int i = 0; i < 6; i++) begin
      tests_run++;
      if (cap_l.size() <= b + i) begin
        tests_failed++; $display("FAIL ramp_pair%0d: got no pair expected %h/%h", i, exp_l[i], exp_r[i]);
      end else if (cap_l[b+i] !== exp_l[i] || cap_r[b+i] !== exp_r[i]) begin
        tests_failed++; $display("FAIL ramp_pair%0d: got %h/%h expected %h/%h", i, cap_l[b+i], cap_r[b+i], exp_l[i], exp_r[i]);
      end
    end
    tests_run++;
    if (consec_err !== 0) begin tests_failed++; $display("FAIL ramp_consecutive: got %0d expected 0", consec_err); end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_short_right();
    test_long_left();
    test_reset_mid();
    test_min_sclk();
    test_back_to_back_ramp();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/i2s_rx.md
I2S_RX -- requirements
Module: i2s_rx

Interface
REQ-001 The module SHALL have parameter AUDIO_DW, default 16, giving the sample word width in bits (legal range 8..32).
REQ-002 The module SHALL have port clk, input, 1 bit, the single system clock; all logic is clocked on its rising edge.
REQ-003 The module SHALL have port reset, input, 1 bit, a synchronous active-high reset.
REQ-004 The module SHALL have port sclk, input, 1 bit, the I2S bit clock, asynchronous to clk.
REQ-005 The module SHALL have port lrclk, input, 1 bit, the I2S word select (0 = left, 1 = right), asynchronous to clk.
REQ-006 The module SHALL have port sdata, input, 1 bit, the I2S serial data, asynchronous to clk.
REQ-007 The module SHALL have port left_chan, output, AUDIO_DW bits, the last complete left sample.
REQ-008 The module SHALL have port right_chan, output, AUDIO_DW bits, the last complete right sample.
REQ-009 The module SHALL have port sample_valid, output, 1 bit, a one-clk pulse when left_chan and right_chan update as a pair.
REQ-010 The module SHALL have port frame_err, output, 1 bit, a one-clk pulse when a slot holds a bit count other than AUDIO_DW.

Function
REQ-011 sclk, lrclk and sdata SHALL each pass through an identical 2-flop synchronizer plus one history flop, preserving their mutual alignment.
REQ-012 An sclk rising edge SHALL be detected as synchronized stage 2 = 1 and history stage = 0; lrclk and sdata SHALL be sampled from stage 2 in that same cycle.
REQ-013 Operation SHALL be guaranteed only when sclk high and sclk low each last at least 2 clk periods.
REQ-014 Framing SHALL be standard I2S: MSB first, MSB on the first sclk rise after an lrclk change, and the previous word's LSB on the rise at which lrclk is first sampled changed.
REQ-015 On each sclk rise, sdata SHALL shift into a AUDIO_DW-bit shift register.
REQ-016 The slot bit counter SHALL count from 1, capped at 255 with no wrap; bits beyond AUDIO_DW SHALL NOT shift in.
REQ-017 A word SHALL complete on the rise at which sampled lrclk differs from the previous sampled lrclk; that rise's bit SHALL be included, and the word's channel SHALL be the previous lrclk value.
REQ-018 On completion with count = AUDIO_DW, a left word SHALL be stored in a pending-left register, setting have_left = 1.
REQ-019 On completion with count = AUDIO_DW, a right word with have_left = 1 SHALL load left_chan and right_chan in the same cycle, pulse sample_valid, and clear have_left.
REQ-020 A right word completing with have_left = 0 SHALL be discarded: outputs unchanged, no sample_valid.
REQ-021 On completion with count != AUDIO_DW, the word SHALL be discarded, frame_err SHALL pulse once, and have_left SHALL clear.
REQ-022 The first slot after reset is partial; it SHALL be discarded without frame_err, tracked by a first_slot flag cleared at the first lrclk change.
REQ-023 After each completion the counter SHALL restart at 0 and the shift register SHALL clear, so the next rise yields count 1 with the MSB.
REQ-024 Outputs SHALL be registered; sample_valid and frame_err SHALL rise on the clk edge after the edge where the completing sclk rise is detected (3 clk after the edge first sampling sclk = 1).
REQ-025 left_chan and right_chan SHALL hold their values between sample_valid pulses.
REQ-026 sample_valid and frame_err SHALL never be high for two consecutive clk cycles.

Reset
REQ-027 While reset = 1: left_chan = 0, right_chan = 0, sample_valid = 0, frame_err = 0, have_left = 0, bit counter = 0, shift register = 0, first_slot = 1.
REQ-028 The synchronizer and history flops SHALL reset to 1 on sclk/lrclk and to 0 on sdata, so no edge is detected on the cycle after reset deasserts.
REQ-029 Reset mid-frame SHALL abandon all partial data; no sample_valid or frame_err SHALL result from the interrupted frame.

Verification
REQ-030 Driver with AUDIO_DW=16, sclk = clk/8, two frames left=0x1234 right=0xABCD -> after the 2nd full frame, left_chan=0x1234, right_chan=0xABCD, exactly one sample_valid per frame after the first.
REQ-031 Right slot shortened to 15 bits -> frame_err pulses once; left_chan and right_chan unchanged; no sample_valid for that frame; next good frame recovers.
REQ-032 Left slot lengthened to 17 bits -> frame_err pulses once, pair discarded, no wrap of the bit counter.
REQ-033 Reset asserted mid left slot, then 3 good frames (0x8001/0x7FFE) -> no pulses from the partial slot; left_chan=0x8001, right_chan=0x7FFE after recovery.
REQ-034 Loopback from the team's I2S serializer (AUDIO_DW=16, ce every 2nd clk) with ramp samples -> received pairs equal transmitted pairs; zero frame_err.
REQ-035 sclk at the minimum 2-clk high/2-clk low with random samples -> all pairs bit-exact, one sample_valid per frame.
